// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenge_sequencer
// Description : Drives an arbiter PUF through repeated clear/launch/settle/
//               sample votes per LFSR challenge. Each response bit is a
//               majority vote. The result is returned over a valid/ready
//               handshake.
// Option      : define PUF_SEQ_UNSTABLE_EN to count non-unanimous bits on
//               unstable_cnt. Without it, unstable_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_sequencer #(
  parameter int NUM_BITS = 16,  // response bits per request, 1..32
  parameter int SETTLE   = 4,   // cycles mux_in held high before sampling, 1..255
  parameter int VOTES    = 5    // evaluations per challenge, odd, 1..15
) (
  input  logic                clk,
  input  logic                rst,          // synchronous, active-low
  input  logic                start,
  input  logic [7:0]          seed,
  output logic [7:0]          ch_out,
  output logic                mux_in,
  output logic                puf_rst,
  input  logic                resp_in,
  output logic                busy,
  output logic                resp_valid,
  output logic [NUM_BITS-1:0] resp_data,
  input  logic                resp_ready,
  output logic [5:0]          unstable_cnt
);

  // Terminal values for the counters. Each value is sized to the counter
  // that it is compared against.
  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [3:0] c_VOTES_LAST  = 4'(VOTES - 1);
  localparam logic [3:0] c_VOTES_HALF  = 4'(VOTES / 2);
  localparam logic [5:0] c_BITS_LAST   = 6'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                state_q,      state_d;
  logic [7:0]            lfsr_q,       lfsr_d;
  logic [7:0]            settle_cnt_q, settle_cnt_d;
  logic [3:0]            vote_idx_q,   vote_idx_d;
  logic [3:0]            ones_q,       ones_d;
  logic [5:0]            bit_idx_q,    bit_idx_d;
  logic [NUM_BITS-1:0]   resp_data_q,  resp_data_d;
  logic                  majority;

  // 8-bit Fibonacci LFSR step. Taps are at bits 7, 5, 4 and 3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  // State and datapath registers. Reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 8'h01;
      settle_cnt_q <= '0;
      vote_idx_q   <= '0;
      ones_q       <= '0;
      bit_idx_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      settle_cnt_q <= settle_cnt_d;
      vote_idx_q   <= vote_idx_d;
      ones_q       <= ones_d;
      bit_idx_q    <= bit_idx_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state, datapath update and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    settle_cnt_d = settle_cnt_q;
    vote_idx_d   = vote_idx_q;
    ones_d       = ones_q;
    bit_idx_d    = bit_idx_q;
    resp_data_d  = resp_data_q;
    majority     = 1'b0;
    mux_in       = 1'b0;
    puf_rst      = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Arbiter latches stay cleared while the block is idle.
        busy    = 1'b0;
        puf_rst = 1'b1;
        if (start) begin
          // An all-zero seed would lock up the LFSR.
          lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
          bit_idx_d   = '0;
          vote_idx_d  = '0;
          ones_d      = '0;
          resp_data_d = '0;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        puf_rst = 1'b1;
        state_d = S_LAUNCH;
      end

      S_LAUNCH: begin
        mux_in       = 1'b1;
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end

      S_SETTLE: begin
        mux_in = 1'b1;
        if (settle_cnt_q == c_SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      S_SAMPLE: begin
        mux_in     = 1'b1;
        ones_d     = ones_q + {3'b000, resp_in};
        vote_idx_d = vote_idx_q + 4'd1;
        state_d    = (vote_idx_q == c_VOTES_LAST) ? S_NEXT : S_CLEAR;
      end

      S_NEXT: begin
        // Resolve the bit by majority, store it LSB first, then move on to
        // the next challenge.
        majority = (ones_q > c_VOTES_HALF);
        for (int i = 0; i < NUM_BITS; i++) begin
          if (bit_idx_q == 6'(i)) begin
            resp_data_d[i] = majority;
          end
        end
        lfsr_d     = lfsr_next(lfsr_q);
        vote_idx_d = '0;
        ones_d     = '0;
        bit_idx_d  = bit_idx_q + 6'd1;
        state_d    = (bit_idx_q == c_BITS_LAST) ? S_DONE : S_CLEAR;
      end

      S_DONE: begin
        // start is ignored here, even when it arrives together with resp_ready.
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ch_out    = lfsr_q;
  assign resp_data = resp_data_q;

`ifdef PUF_SEQ_UNSTABLE_EN
  localparam logic [3:0] c_VOTES_ALL = 4'(VOTES);

  logic [5:0] unstable_q, unstable_d;

  // Count bits whose votes were not unanimous. The count clears on an
  // accepted start and holds through DONE and IDLE.
  always_comb begin
    unstable_d = unstable_q;
    if (state_q == S_IDLE && start) begin
      unstable_d = '0;
    end else if (state_q == S_NEXT && ones_q != 4'd0 && ones_q != c_VOTES_ALL) begin
      unstable_d = unstable_q + 6'd1;
    end
  end

  // Unstable-bit counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      unstable_q <= '0;
    end else begin
      unstable_q <= unstable_d;
    end
  end

  assign unstable_cnt = unstable_q;
`else
  assign unstable_cnt = 6'd0;
`endif

endmodule
`default_nettype wire
